// File: rtl/hist_agc_if.sv
// Histogram read port: the controller drives line select and lock, the
// histogram block returns its valid flag and the addressed line's counts.
interface hist_agc_if;
  logic [7:0]  hist_addr;
  logic        hist_lock;
  logic        hist_valid;
  logic [31:0] hist_result;

  modport master (
    output hist_addr,
    output hist_lock,
    input  hist_valid,
    input  hist_result
  );

  modport slave (
    input  hist_addr,
    input  hist_lock,
    output hist_valid,
    output hist_result
  );
endinterface

// File: rtl/hist_agc_ctrl.sv
// Sweeps the histogram line by line, samples the locked {sig, mag} word and
// runs a per-line gain loop on the magnitude count plus a DC-offset flag.
module hist_agc_ctrl #(
  parameter int unsigned LINES     = 1,
  parameter int unsigned GAIN_W    = 5,
  parameter int unsigned GAIN_INIT = 16,
  parameter logic [15:0] MAG_LO    = 16'd18000,
  parameter logic [15:0] MAG_HI    = 16'd25000,
  parameter logic [15:0] SIG_LO    = 16'd30000,
  parameter logic [15:0] SIG_HI    = 16'd35535,
  parameter int unsigned WAIT_CYC  = 4,
  parameter logic [31:0] INTERVAL  = 32'd65536
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  hist_agc_if.master                hist,
  output logic [LINES*GAIN_W-1:0]   gain_vec,
  output logic [LINES-1:0]          dc_alarm,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int unsigned IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [GAIN_W-1:0] GAIN_MAX  = '1;
  localparam logic [GAIN_W-1:0] GAIN_RST  = GAIN_W'(GAIN_INIT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_FREEZE,
    S_SAMPLE,
    S_UPDATE,
    S_GAP
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [31:0]         timer;
  logic [15:0]         sig_s;
  logic [15:0]         mag_s;
  logic [GAIN_W-1:0]   gain_cur;
  logic [GAIN_W-1:0]   gain_nxt;
  logic                dc_nxt;

  assign idx_nxt = idx + IDX_W'(1);

  // Gain step and DC flag for the line currently being updated.
  always_comb begin
    gain_cur = gain_vec[idx*GAIN_W +: GAIN_W];
    gain_nxt = gain_cur;
    if (mag_s < MAG_LO) begin
      if (gain_cur != GAIN_MAX) gain_nxt = gain_cur + GAIN_W'(1);
    end else if (mag_s > MAG_HI) begin
      if (gain_cur != '0) gain_nxt = gain_cur - GAIN_W'(1);
    end
    dc_nxt = (sig_s < SIG_LO) || (sig_s > SIG_HI);
  end

  // Outputs are written on the transition into a state so that hist_addr and
  // hist_lock already carry that state's values during its first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      wcnt           <= '0;
      timer          <= '0;
      sig_s          <= '0;
      mag_s          <= '0;
      hist.hist_addr <= '0;
      hist.hist_lock <= 1'b1;
      gain_vec       <= {LINES{GAIN_RST}};
      dc_alarm       <= '0;
      busy           <= 1'b0;
      sweep_done     <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          hist.hist_lock <= 1'b1;
          idx            <= '0;
          if (enable && hist.hist_valid && (timer == '0)) begin
            state          <= S_SET;
            hist.hist_addr <= '0;
            hist.hist_lock <= 1'b0;
            busy           <= 1'b1;
          end
        end
        S_SET: begin
          state <= S_SETTLE;
          wcnt  <= WCNT_LOAD;
        end
        S_SETTLE: begin
          if (wcnt == '0) begin
            state          <= S_FREEZE;
            wcnt           <= WCNT_LOAD;
            hist.hist_lock <= 1'b1;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        S_FREEZE: begin
          if (wcnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        S_SAMPLE: begin
          sig_s <= hist.hist_result[31:16];
          mag_s <= hist.hist_result[15:0];
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          gain_vec[idx*GAIN_W +: GAIN_W] <= gain_nxt;
          dc_alarm[idx]                  <= dc_nxt;
          if (idx == LAST_IDX) begin
            state      <= S_GAP;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            timer      <= INTERVAL - 32'd1;
          end else begin
            state          <= S_SET;
            idx            <= idx_nxt;
            hist.hist_addr <= 8'(idx_nxt);
            hist.hist_lock <= 1'b0;
          end
        end
        S_GAP: begin
          // The IDLE cycle that follows completes the inter-sweep interval.
          if (timer <= 32'd1) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_agc_ctrl.sv
// Directed bench for hist_agc_ctrl with a 4-line histogram model that has a
// 2-flop synchronizer on addr/lock plus a result register.
module tb_hist_agc_ctrl;

  localparam int unsigned LINES    = 4;
  localparam int unsigned GAIN_W   = 5;
  localparam int unsigned WAIT_CYC = 4;
  localparam int unsigned INTV     = 40;
  localparam int unsigned SWEEP    = LINES * (3 + 2 * WAIT_CYC);
  localparam int unsigned PERIOD   = SWEEP + INTV;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b0;
  logic [LINES*GAIN_W-1:0] gain_vec;
  logic [LINES-1:0]        dc_alarm;
  logic                    busy;
  logic                    sweep_done;

  hist_agc_if hif ();

  hist_agc_ctrl #(
    .LINES    (LINES),
    .GAIN_W   (GAIN_W),
    .GAIN_INIT(16),
    .WAIT_CYC (WAIT_CYC),
    .INTERVAL (32'(INTV))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .hist      (hif.master),
    .gain_vec  (gain_vec),
    .dc_alarm  (dc_alarm),
    .busy      (busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // Histogram model: synchronized addr/lock, result tracks addr while unlocked.
  logic [15:0] mag_tab [LINES];
  logic [15:0] sig_tab [LINES];
  logic [7:0]  addr_s1 = '0, addr_s2 = '0;
  logic        lock_s1 = 1'b1, lock_s2 = 1'b1;
  logic [31:0] result_q = '0;
  logic        valid = 1'b0;
  int          cyc = 0;

  assign hif.hist_result = result_q;
  assign hif.hist_valid  = valid;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    addr_s1 <= hif.hist_addr;
    addr_s2 <= addr_s1;
    lock_s1 <= hif.hist_lock;
    lock_s2 <= lock_s1;
    if (!lock_s2) result_q <= {sig_tab[addr_s2[1:0]], mag_tab[addr_s2[1:0]]};
  end

  int passed = 0;
  int total  = 0;

  function automatic logic [LINES*GAIN_W-1:0] rep(input logic [GAIN_W-1:0] g);
    return {LINES{g}};
  endfunction

  task automatic set_tabs(input logic [15:0] m0, m1, m2, m3, s0, s1, s2, s3);
    mag_tab[0] = m0; mag_tab[1] = m1; mag_tab[2] = m2; mag_tab[3] = m3;
    sig_tab[0] = s0; sig_tab[1] = s1; sig_tab[2] = s2; sig_tab[3] = s3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (hif.hist_addr !== 8'd0) $display("FAIL reset_addr got %0d want 0", hif.hist_addr); else passed++;
    total++; if (hif.hist_lock !== 1'b1) $display("FAIL reset_lock got %b want 1", hif.hist_lock); else passed++;
    total++; if (gain_vec !== rep(5'd16)) $display("FAIL reset_gain got %h want %h", gain_vec, rep(5'd16)); else passed++;
    total++; if (dc_alarm !== 4'b0000) $display("FAIL reset_dc got %b want 0000", dc_alarm); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (sweep_done !== 1'b0) $display("FAIL reset_done got %b want 0", sweep_done); else passed++;
  endtask

  task automatic test_increment();
    bit ok;
    int last;
    int exp;
    do_reset();
    set_tabs(10000, 10000, 10000, 10000, 32768, 32768, 32768, 32768);
    valid = 1'b1; enable = 1'b1;
    last = 0;
    for (int s = 1; s <= 18; s++) begin
      wait_done(2 * PERIOD, ok);
      total++; if (!ok) $display("FAIL inc_timeout sweep %0d got no sweep_done", s); else passed++;
      exp = (16 + s > 31) ? 31 : 16 + s;
      total++; if (gain_vec !== rep(5'(exp))) $display("FAIL inc_gain sweep %0d got %h want %h", s, gain_vec, rep(5'(exp))); else passed++;
      if (s > 1) begin
        total++; if (cyc - last !== PERIOD) $display("FAIL inc_period got %0d want %0d", cyc - last, PERIOD); else passed++;
      end
      last = cyc;
    end
    total++; if (dc_alarm !== 4'b0000) $display("FAIL inc_dc got %b want 0000", dc_alarm); else passed++;
  endtask

  task automatic test_decrement();
    bit ok;
    int exp;
    do_reset();
    set_tabs(40000, 40000, 40000, 40000, 32768, 32768, 32768, 32768);
    enable = 1'b1;
    for (int s = 1; s <= 18; s++) begin
      wait_done(2 * PERIOD, ok);
      exp = (s >= 16) ? 0 : 16 - s;
      total++; if (!ok || gain_vec !== rep(5'(exp))) $display("FAIL dec_gain sweep %0d got %h want %h", s, gain_vec, rep(5'(exp))); else passed++;
    end
  endtask

  task automatic test_boundary();
    bit ok;
    do_reset();
    set_tabs(18000, 25000, 18000, 25000, 30000, 35535, 30000, 35535);
    enable = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      wait_done(2 * PERIOD, ok);
      total++; if (!ok || gain_vec !== rep(5'd16)) $display("FAIL bnd_gain sweep %0d got %h want %h", s, gain_vec, rep(5'd16)); else passed++;
      total++; if (dc_alarm !== 4'b0000) $display("FAIL bnd_dc sweep %0d got %b want 0000", s, dc_alarm); else passed++;
    end
  endtask

  task automatic test_per_line();
    bit ok;
    logic [LINES*GAIN_W-1:0] exp;
    do_reset();
    set_tabs(17999, 40000, 18000, 25001, 30000, 29999, 35535, 35536);
    enable = 1'b1;
    wait_done(2 * PERIOD, ok);
    exp = {5'd15, 5'd16, 5'd15, 5'd17};
    total++; if (!ok || gain_vec !== exp) $display("FAIL line_gain got %h want %h", gain_vec, exp); else passed++;
    total++; if (dc_alarm !== 4'b1010) $display("FAIL line_dc got %b want 1010", dc_alarm); else passed++;
  endtask

  task automatic test_dc_alarm();
    bit ok;
    do_reset();
    set_tabs(20000, 20000, 20000, 20000, 32768, 32768, 20000, 32768);
    enable = 1'b1;
    wait_done(2 * PERIOD, ok);
    total++; if (!ok || dc_alarm !== 4'b0100) $display("FAIL dc_set got %b want 0100", dc_alarm); else passed++;
    sig_tab[2] = 16'd32768;
    wait_done(2 * PERIOD, ok);
    total++; if (!ok || dc_alarm !== 4'b0000) $display("FAIL dc_clear got %b want 0000", dc_alarm); else passed++;
    total++; if (gain_vec !== rep(5'd16)) $display("FAIL dc_gain got %h want %h", gain_vec, rep(5'd16)); else passed++;
  endtask

  task automatic test_timing();
    bit ok;
    bit seen;
    int lo_n;
    int hi_n;
    int c0;
    do_reset();
    set_tabs(20000, 20000, 20000, 20000, 32768, 32768, 32768, 32768);
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!hif.hist_lock) begin seen = 1'b1; break; end
    end
    c0 = cyc;
    total++; if (!seen) $display("FAIL tim_start got lock %b want 0", hif.hist_lock); else passed++;
    total++; if (busy !== 1'b1 || hif.hist_addr !== 8'd0) $display("FAIL tim_set got busy %b addr %0d want 1 0", busy, hif.hist_addr); else passed++;
    lo_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!hif.hist_lock) lo_n++; else break;
    end
    total++; if (lo_n !== WAIT_CYC + 1) $display("FAIL tim_unlock got %0d want %0d", lo_n, WAIT_CYC + 1); else passed++;
    hi_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hif.hist_lock) hi_n++; else break;
    end
    total++; if (hi_n !== WAIT_CYC + 2) $display("FAIL tim_lock got %0d want %0d", hi_n, WAIT_CYC + 2); else passed++;
    total++; if (hif.hist_addr !== 8'd1) $display("FAIL tim_addr1 got %0d want 1", hif.hist_addr); else passed++;
    wait_done(2 * PERIOD, ok);
    total++; if (!ok || cyc - c0 !== SWEEP) $display("FAIL tim_sweep got %0d want %0d", cyc - c0, SWEEP); else passed++;
  endtask

  task automatic test_no_valid();
    int lo_n;
    bit seen;
    do_reset();
    valid = 1'b0;
    enable = 1'b1;
    lo_n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!hif.hist_lock || busy) lo_n++;
    end
    total++; if (lo_n !== 0) $display("FAIL nv_idle got %0d active cycles want 0", lo_n); else passed++;
    valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!hif.hist_lock) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL nv_start got lock %b want 0", hif.hist_lock); else passed++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int act;
    do_reset();
    set_tabs(10000, 10000, 10000, 10000, 32768, 32768, 32768, 32768);
    enable = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_done(2 * SWEEP, ok);
    total++; if (!ok || gain_vec !== rep(5'd17)) $display("FAIL en_finish got %h want %h", gain_vec, rep(5'd17)); else passed++;
    act = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (!hif.hist_lock || busy) act++;
    end
    total++; if (act !== 0) $display("FAIL en_nostart got %0d active cycles want 0", act); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_tabs(10000, 10000, 10000, 10000, 20000, 32768, 32768, 32768);
    enable = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    repeat (15) @(negedge clk);
    total++; if (gain_vec[4:0] !== 5'd17 || dc_alarm !== 4'b0001) $display("FAIL rm_pre got gain0 %0d dc %b want 17 0001", gain_vec[4:0], dc_alarm); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || hif.hist_lock !== 1'b1) $display("FAIL rm_ctrl got busy %b lock %b want 0 1", busy, hif.hist_lock); else passed++;
    total++; if (gain_vec !== rep(5'd16) || dc_alarm !== 4'b0000) $display("FAIL rm_state got %h dc %b want %h 0000", gain_vec, dc_alarm, rep(5'd16)); else passed++;
    total++; if (hif.hist_addr !== 8'd0) $display("FAIL rm_addr got %0d want 0", hif.hist_addr); else passed++;
    reset = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    set_tabs(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_increment();
    test_decrement();
    test_boundary();
    test_per_line();
    test_dc_alarm();
    test_timing();
    test_no_valid();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
